// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues I-cache reads, and feeds decode
// through a valid/ready handshake with a one-entry skid buffer.
//
//   state     | meaning
//   S_FETCH   | request at pc every cycle, deliver or skid on completion
//   S_BLOCKED | skid holds a fetched instruction, decode is back-pressuring
//   S_DRAIN   | stalled access from before a redirect must finish, data dropped
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_pc,
  input  logic [31:0] i_pc_next,
  input  logic        i_redirect,
  output logic        o_icache_ren,
  output logic [31:0] o_icache_addr,
  input  logic        i_icache_stall,
  input  logic [31:0] i_icache_rdata,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_BLOCKED = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic        r_id_valid;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;

  logic        w_complete;
  logic        w_slot_free;

  // Request depends only on state (and reset), never on id_ready.
  assign o_icache_ren  = !i_rst && (r_state != S_BLOCKED);
  assign o_icache_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign w_complete    = o_icache_ren && !i_icache_stall;
  assign w_slot_free   = !r_id_valid || i_id_ready;

  assign o_pc       = r_pc;
  assign o_id_valid = r_id_valid;
  assign o_id_inst  = r_id_inst;
  assign o_id_pc    = r_id_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_skid_inst  <= '0;
      r_skid_pc    <= '0;
      r_id_valid   <= 1'b0;
      r_id_inst    <= NOP_INST;
      r_id_pc      <= '0;
    end else if (i_redirect) begin
      r_pc       <= i_pc_next;
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
      // Leaving BLOCKED abandons the skid entry; a stalled FETCH must drain.
      if (r_state == S_FETCH && i_icache_stall) begin
        r_drain_addr <= r_pc;
        r_state      <= S_DRAIN;
      end else if (r_state != S_DRAIN) begin
        r_state <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_complete) begin
            r_pc <= i_pc_next;
            if (w_slot_free) begin
              r_id_inst  <= i_icache_rdata;
              r_id_pc    <= r_pc;
              r_id_valid <= 1'b1;
            end else begin
              r_skid_inst <= i_icache_rdata;
              r_skid_pc   <= r_pc;
              r_state     <= S_BLOCKED;
            end
          end else if (i_id_ready) begin
            r_id_valid <= 1'b0;
          end
        end
        S_BLOCKED: begin
          if (i_id_ready) begin
            r_id_inst <= r_skid_inst;
            r_id_pc   <= r_skid_pc;
            r_state   <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (i_id_ready) r_id_valid <= 1'b0;
          if (w_complete) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, stall, back-pressure,
// redirects (plain and during a stall), and reset while blocked.
module tb_inst_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect;
  logic        icache_ren;
  logic [31:0] icache_addr;
  logic        icache_stall;
  logic [31:0] icache_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  logic        use_tgt;
  logic [31:0] tgt;

  int tests = 0;
  int fails = 0;

  inst_fetch dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_pc           (pc),
    .i_pc_next      (pc_next),
    .i_redirect     (redirect),
    .o_icache_ren   (icache_ren),
    .o_icache_addr  (icache_addr),
    .i_icache_stall (icache_stall),
    .i_icache_rdata (icache_rdata),
    .o_id_valid     (id_valid),
    .i_id_ready     (id_ready),
    .o_id_inst      (id_inst),
    .o_id_pc        (id_pc)
  );

  // Environment: PC calculator (pc+4 unless a target is forced) and zero-wait memory.
  assign pc_next      = use_tgt ? tgt : pc + 32'd4;
  assign icache_rdata = icache_addr ^ XORK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; icache_stall = 1'b0; id_ready = 1'b1;
    use_tgt = 1'b0; tgt = '0;

    // Reset cycle
    tick();
    #1;
    chk("rst_ren",   {31'd0, icache_ren}, 32'd0);
    chk("rst_valid", {31'd0, id_valid},   32'd0);
    chk("rst_inst",  id_inst, NOP);
    chk("rst_idpc",  id_pc,   32'd0);
    chk("rst_pc",    pc,      32'd0);
    rst = 1'b0;
    #1;
    chk("first_ren",  {31'd0, icache_ren}, 32'd1);
    chk("first_addr", icache_addr, 32'd0);

    // Zero-wait streaming: 0,4,8,12
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("stream_valid", {31'd0, id_valid}, 32'd1);
      chk("stream_idpc",  id_pc, 32'(4 * k));
      chk("stream_inst",  id_inst, 32'(4 * k) ^ XORK);
    end

    // Redirect to 0x100 during unstalled fetch of 0x10
    chk("redir_addr", icache_addr, 32'h10);
    use_tgt = 1'b1; tgt = 32'h100; redirect = 1'b1;
    tick();
    redirect = 1'b0; use_tgt = 1'b0;
    #1;
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_nop",   id_inst, NOP);
    chk("redir_addr2", icache_addr, 32'h100);
    tick();
    #1;
    chk("redir_tgt_valid", {31'd0, id_valid}, 32'd1);
    chk("redir_tgt_idpc",  id_pc, 32'h100);
    chk("redir_tgt_inst",  id_inst, 32'hA5A5_0100);

    // Redirect to 0x8, then stall 3 cycles there
    use_tgt = 1'b1; tgt = 32'h8; redirect = 1'b1;
    tick();
    redirect = 1'b0; use_tgt = 1'b0; icache_stall = 1'b1;
    #1;
    chk("stall_addr0", icache_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) icache_stall = 1'b0;
      #1;
      chk("stall_addr",  icache_addr, 32'h8);
      chk("stall_valid", {31'd0, id_valid}, 32'd0);
      chk("stall_pc",    pc, 32'h8);
    end
    tick();
    #1;
    chk("stall_done_valid", {31'd0, id_valid}, 32'd1);
    chk("stall_done_idpc",  id_pc, 32'h8);
    chk("stall_done_addr",  icache_addr, 32'hC);

    // Back-pressure: id_ready low for 4 cycles
    id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) id_ready = 1'b1;
      #1;
      chk("bp_ren",   {31'd0, icache_ren}, 32'd0);
      chk("bp_valid", {31'd0, id_valid}, 32'd1);
      chk("bp_idpc",  id_pc, 32'h8);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("bp_rel_valid", {31'd0, id_valid}, 32'd1);
      chk("bp_rel_idpc",  id_pc, 32'hC + 32'(4 * k));
      chk("bp_rel_inst",  id_inst, (32'hC + 32'(4 * k)) ^ XORK);
    end

    // Redirect to 0x20, stall there; redirect to 0x200 on the second stall cycle
    use_tgt = 1'b1; tgt = 32'h20; redirect = 1'b1;
    tick();
    redirect = 1'b0; use_tgt = 1'b0; icache_stall = 1'b1;
    #1;
    chk("drn_addr0", icache_addr, 32'h20);
    tick();
    use_tgt = 1'b1; tgt = 32'h200; redirect = 1'b1;
    #1;
    chk("drn_addr1", icache_addr, 32'h20);
    tick();
    redirect = 1'b0; use_tgt = 1'b0;
    #1;
    chk("drn_addr2", icache_addr, 32'h20);
    chk("drn_ren",   {31'd0, icache_ren}, 32'd1);
    chk("drn_pc",    pc, 32'h200);
    chk("drn_valid", {31'd0, id_valid}, 32'd0);
    tick();
    icache_stall = 1'b0;
    #1;
    chk("drn_addr3", icache_addr, 32'h20);
    tick();
    #1;
    chk("drn_next_addr", icache_addr, 32'h200);
    chk("drn_dropped",   {31'd0, id_valid}, 32'd0);
    tick();
    #1;
    chk("drn_tgt_valid", {31'd0, id_valid}, 32'd1);
    chk("drn_tgt_idpc",  id_pc, 32'h200);
    chk("drn_tgt_inst",  id_inst, 32'hA5A5_0200);

    // Enter BLOCKED, then reset
    id_ready = 1'b0;
    tick();
    #1;
    chk("blk_ren", {31'd0, icache_ren}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; id_ready = 1'b1;
    #1;
    chk("blkrst_pc",    pc, 32'd0);
    chk("blkrst_valid", {31'd0, id_valid}, 32'd0);
    chk("blkrst_inst",  id_inst, NOP);
    chk("blkrst_addr",  icache_addr, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      chk("blkrst_valid2", {31'd0, id_valid}, 32'd1);
      chk("blkrst_idpc",   id_pc, 32'(4 * k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
